// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the write-only I2C master.
// Holds the FSM state enum, ACK/NACK line levels and default sync depth.
package i2c_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      RSTART,
      STOP
   } state_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_clk_sync.sv
// Synchronises the i2c_clk bit-rate reference into core_clk and derives
// one-cycle pulses: rise_t, fall_t and data_t (fall_t delayed one cycle).
// Ports: core_clk, rst_n, i2c_clk in; rise_t, fall_t, data_t out.
module i2c_clk_sync
   import i2c_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic core_clk,
   input  logic rst_n,
   input  logic i2c_clk,
   output logic rise_t,
   output logic fall_t,
   output logic data_t
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= '0;
         prev   <= 1'b0;
         data_t <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], i2c_clk};
         prev   <= sync[SYNC_STAGES-1];
         data_t <= fall_t;
      end
   end

   assign rise_t = sync[SYNC_STAGES-1] & ~prev;
   assign fall_t = ~sync[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/i2c_master_wr.sv
// Write-only I2C master: START, address byte, ACK, data byte, ACK, STOP/RSTART.
// Ports: core_clk, rst_n, i2c_clk, enable, slave_address[8], data_in[8],
//        sda_in, repeated_start_cond in; sda_out, scl_out out (1 = released).
// Option: I2C_CTRL_NACK_STOP_EN aborts to STOP when an ACK slot reads NACK.
module i2c_master_wr
   import i2c_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic       core_clk,
   input  logic       rst_n,
   input  logic       i2c_clk,
   input  logic       enable,
   input  logic [7:0] slave_address,
   input  logic [7:0] data_in,
   input  logic       sda_in,
   input  logic       repeated_start_cond,
   output logic       sda_out,
   output logic       scl_out
);

   logic       rise_t;
   logic       fall_t;
   logic       data_t;
   state_t     state;
   logic [2:0] cnt;
   logic [7:0] addr_r;
   logic [7:0] data_r;
   logic [7:0] cur_byte;
   logic       ack_r;
   logic       bus_free;

   i2c_clk_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .core_clk(core_clk),
      .rst_n   (rst_n),
      .i2c_clk (i2c_clk),
      .rise_t  (rise_t),
      .fall_t  (fall_t),
      .data_t  (data_t)
   );

   assign cur_byte = (state == ADDR) ? addr_r : data_r;

`ifndef I2C_CTRL_NACK_STOP_EN
   logic unused_ack;
   assign unused_ack = ack_r;
`endif

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sda_out  <= 1'b1;
         scl_out  <= 1'b1;
         cnt      <= 3'd7;
         addr_r   <= '0;
         data_r   <= '0;
         ack_r    <= ACK;
         bus_free <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               scl_out <= 1'b1;
               sda_out <= 1'b1;
               // after a STOP one whole rise_t must pass before a new START
               if (rise_t) begin
                  if (enable && bus_free) begin
                     sda_out <= 1'b0;
                     addr_r  <= slave_address;
                     data_r  <= data_in;
                     state   <= START;
                  end else begin
                     bus_free <= 1'b1;
                  end
               end
            end
            START: begin
               if (fall_t) scl_out <= 1'b0;
               if (data_t) begin
                  sda_out <= addr_r[7];
                  cnt     <= 3'd7;
                  state   <= ADDR;
               end
            end
            ADDR, DATA: begin
               if (rise_t) scl_out <= 1'b1;
               if (fall_t) scl_out <= 1'b0;
               if (data_t) begin
                  if (cnt == 3'd0) begin
                     sda_out <= 1'b1;
                     state   <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                  end else begin
                     cnt     <= cnt - 3'd1;
                     sda_out <= cur_byte[cnt - 3'd1];
                  end
               end
            end
            ADDR_ACK, DATA_ACK: begin
               if (rise_t) begin
                  scl_out <= 1'b1;
                  ack_r   <= sda_in;
               end
               if (fall_t) scl_out <= 1'b0;
               if (data_t) begin
`ifdef I2C_CTRL_NACK_STOP_EN
                  if (ack_r == NACK) begin
                     sda_out <= 1'b0;
                     state   <= STOP;
                  end else
`endif
                  if (state == ADDR_ACK) begin
                     sda_out <= data_r[7];
                     cnt     <= 3'd7;
                     state   <= DATA;
                  end else if (repeated_start_cond) begin
                     sda_out <= 1'b1;
                     state   <= RSTART;
                  end else begin
                     sda_out <= 1'b0;
                     state   <= STOP;
                  end
               end
            end
            RSTART: begin
               if (rise_t) scl_out <= 1'b1;
               // SCL already high from the previous rise: pull SDA low
               if (scl_out && !rise_t) begin
                  sda_out <= 1'b0;
                  addr_r  <= slave_address;
                  data_r  <= data_in;
                  state   <= START;
               end
            end
            STOP: begin
               if (rise_t) scl_out <= 1'b1;
               if (scl_out && !rise_t) begin
                  sda_out  <= 1'b1;
                  bus_free <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Scoreboard bench for i2c_master_wr: decodes START/byte/STOP events
// off the bus and compares them against expected events queued at stimulus.
module tb_i2c_master_wr;

   localparam int EV_S = 'h100;
   localparam int EV_P = 'h200;

   logic       core_clk = 1'b0;
   logic       rst_n;
   logic       i2c_clk = 1'b0;
   logic       enable;
   logic [7:0] slave_address;
   logic [7:0] data_in;
   logic       sda_in;
   logic       repeated_start_cond;
   logic       sda_out;
   logic       scl_out;

   int n_chk = 0;
   int n_err = 0;
   int exp_q[$];
   int n_start = 0;
   int n_stop = 0;
   int n_byte = 0;
   int trans = 0;
   int cyc = 0;
   int stop_cyc = 0;
   bit gap_chk = 0;

   i2c_master_wr dut (
      .core_clk           (core_clk),
      .rst_n              (rst_n),
      .i2c_clk            (i2c_clk),
      .enable             (enable),
      .slave_address      (slave_address),
      .data_in            (data_in),
      .sda_in             (sda_in),
      .repeated_start_cond(repeated_start_cond),
      .sda_out            (sda_out),
      .scl_out            (scl_out)
   );

   always #5 core_clk = ~core_clk;

   initial begin
      #3;
      forever #40 i2c_clk = ~i2c_clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic sb(input int code);
      if (exp_q.size() == 0) chk("sb_extra", code, 32'hFFFF_FFFF);
      else chk("sb_event", code, exp_q.pop_front());
   endtask

   // bus monitor, sampled on the falling core_clk edge
   logic       psda;
   logic       pscl;
   logic [7:0] sh;
   int         bitcnt;

   always @(negedge core_clk) begin
      cyc++;
      if (!rst_n) begin
         psda   = 1'b1;
         pscl   = 1'b1;
         bitcnt = 0;
      end else begin
         if (sda_out !== psda || scl_out !== pscl) trans++;
         if (pscl && scl_out && sda_out !== psda) begin
            bitcnt = 0;
            if (!sda_out) begin
               if (gap_chk)
                  chk("bus_free_gap", 32'((cyc - stop_cyc) >= 8), 1);
               n_start++;
               sb(EV_S);
            end else begin
               stop_cyc = cyc;
               n_stop++;
               sb(EV_P);
            end
         end else if (!pscl && scl_out) begin
            sh = {sh[6:0], sda_out};
            bitcnt++;
            if (bitcnt == 8) begin
               n_byte++;
               sb(int'(sh));
            end
            if (bitcnt == 9) bitcnt = 0;
         end
         psda = sda_out;
         pscl = scl_out;
      end
   end

   function automatic int evcnt(input int sel);
      case (sel)
         0: return n_start;
         1: return n_stop;
         default: return n_byte;
      endcase
   endfunction

   task automatic wait_ev(input string tag, input int sel, input int target);
      int b;
      b = 0;
      while (evcnt(sel) < target && b < 2000) begin
         @(negedge core_clk);
         b++;
      end
      if (evcnt(sel) < target) chk(tag, evcnt(sel), target);
   endtask

   task automatic drain(input string tag);
      repeat (20) @(negedge core_clk);
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic one_frame(input string tag);
      int s;
      int p;
      s = n_start;
      p = n_stop;
      enable = 1'b1;
      wait_ev({tag, "_start_to"}, 0, s + 1);
      enable = 1'b0;
      wait_ev({tag, "_stop_to"}, 1, p + 1);
      drain({tag, "_drain"});
   endtask

   initial begin
      int s;
      int p;
      int b;
      rst_n = 1'b0;
      enable = 1'b0;
      slave_address = 8'h00;
      data_in = 8'h00;
      sda_in = 1'b0;
      repeated_start_cond = 1'b0;

      // 1: reset and idle
      #40;
      chk("rst_sda", sda_out, 1);
      chk("rst_scl", scl_out, 1);
      #40;
      @(negedge core_clk);
      rst_n = 1'b1;
      repeat (40) @(negedge core_clk);
      chk("idle_sda", sda_out, 1);
      chk("idle_scl", scl_out, 1);
      chk("idle_trans", trans, 0);

      // 2: basic write with ACK
      slave_address = 8'hF0;
      data_in = 8'h01;
      exp_q = '{EV_S, 'hF0, 'h01, EV_P};
      one_frame("t2");

      // 3: NACK from slave
      sda_in = 1'b1;
`ifdef I2C_CTRL_NACK_STOP_EN
      exp_q = '{EV_S, 'hF0, EV_P};
`else
      exp_q = '{EV_S, 'hF0, 'h01, EV_P};
`endif
      one_frame("t3");
      sda_in = 1'b0;

      // 4: repeated start, address resent
      repeated_start_cond = 1'b1;
      exp_q = '{EV_S, 'hF0, 'h01, EV_S, 'hF0, 'h01, EV_P};
      s = n_start;
      p = n_stop;
      enable = 1'b1;
      wait_ev("t4_start_to", 0, s + 1);
      enable = 1'b0;
      wait_ev("t4_rstart_to", 0, s + 2);
      repeated_start_cond = 1'b0;
      wait_ev("t4_stop_to", 1, p + 1);
      chk("t4_no_stop_between", n_stop, p + 1);
      drain("t4_drain");

      // 5: back-to-back frames, inputs re-latched only at next START
      gap_chk = 1'b1;
      exp_q = '{EV_S, 'hF0, 'h01, EV_P, EV_S, 'hA5, 'h3C, EV_P};
      s = n_start;
      p = n_stop;
      enable = 1'b1;
      wait_ev("t5_start1_to", 0, s + 1);
      slave_address = 8'hA5;
      data_in = 8'h3C;
      wait_ev("t5_start2_to", 0, s + 2);
      enable = 1'b0;
      wait_ev("t5_stop2_to", 1, p + 2);
      drain("t5_drain");
      gap_chk = 1'b0;

      // 6: reset asserted during the data byte
      slave_address = 8'hF0;
      data_in = 8'h55;
      exp_q = '{EV_S, 'hF0};
      b = n_byte;
      enable = 1'b1;
      wait_ev("t6_addr_to", 2, b + 1);
      enable = 1'b0;
      repeat (20) @(negedge core_clk);
      chk("t6_scl_low_before", scl_out, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_sda", sda_out, 1);
      chk("t6_rst_scl", scl_out, 1);
      chk("t6_q_empty", exp_q.size(), 0);
      exp_q.delete();
      repeat (5) @(negedge core_clk);
      rst_n = 1'b1;
      trans = 0;
      repeat (40) @(negedge core_clk);
      chk("t6_idle_trans", trans, 0);
      chk("t6_idle_sda", sda_out, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
